uart_crc_receiver: RTL and testbench
====================================

# uart_crc_receiver

Serial receiver for the CRC-protected UART frame used on the board link: one start bit (0), 8 data bits LSB-first, 16 CRC bits LSB-first, one stop bit (1), 26 bit times total. Sits directly downstream of the UART transmitter on the far end of the line. It oversamples the line with the system clock, deserialises the frame and recomputes CRC-16 over the data byte. It presents byte, received CRC and error flags to the consumer with a single-cycle valid strobe.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate
- CRC_POLY, 16'h1021, CRC-16 generator polynomial (MSB-first, non-reflected)
- CRC_INIT, 16'hFFFF, CRC register preset
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx_in  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  received data byte
- crc_out  output  16  received CRC field
- rx_valid  output  1  one-cycle strobe: frame complete, outputs updated
- crc_err  output  1  recomputed CRC != crc_out; qualifies rx_valid
- frame_err  output  1  stop bit sampled 0; qualifies rx_valid
- rx_busy  output  1  high from start-edge detection until return to IDLE

## Operation
- rx_in passes through a 2-flop synchroniser (both flops reset to 1); all logic uses the synchronised signal rxs.
- DIV = CLK_FREQ/BAUD_RATE (integer), HALF = DIV/2; 16-bit baud counter; requires 4 <= DIV <= 65535.
- States: IDLE -> START -> DATA -> CRC -> STOP -> IDLE.
- IDLE: arm on falling edge of rxs (previous 1, current 0); a line held low never re-arms until rxs has been 1 for at least one cycle.
- START: at counter == HALF, rxs still 0 -> DATA; rxs 1 -> false start, back to IDLE, no strobe.
- DATA: 8 samples spaced DIV, shifted in LSB-first into data shift register.
- CRC: 16 samples spaced DIV, LSB-first into CRC shift register.
- STOP: sample spaced DIV; latch data_out, crc_out, frame_err = ~rxs, crc_err; return to IDLE next cycle.
- CRC: CRC-16 over the 8 data bits, MSB (bit 7) first, preset CRC_INIT, no final XOR; computed combinationally from the data shift register at the STOP sample.
- rx_valid pulses for every completed frame, including errored ones; flags hold until the next rx_valid.

## Timing
- Reset values: data_out 0, crc_out 0, rx_valid 0, crc_err 0, frame_err 0, rx_busy 0, state IDLE.
- Cycle 0 = first cycle rxs is 0 in IDLE; rx_busy high from cycle 1.
- Start check at cycle HALF; frame bit k (k = 1..25) sampled at HALF + k*DIV.
- rx_valid, data_out, crc_out, crc_err and frame_err update at HALF + 25*DIV + 1; rx_busy low the same cycle.
- Pin-to-rxs latency is 2 cycles.
- Back-to-back frames: a start edge arriving in the cycle after the STOP sample is accepted.
- reset_n asserted mid-frame: immediate return to IDLE with all outputs at reset values; no strobe for the partial frame.

## Configuration
- UART_RX_CRC_CHECK_EN defined: CRC recomputation present; crc_err as specified.
- Undefined: CRC logic omitted; crc_err tied 0. crc_out is still captured and framing is unchanged.

## Test plan
- Frame data 0x00, CRC 0xE1F0, stop 1 at DIV=5208 -> one rx_valid pulse at the computed cycle; data_out 0x00, crc_out 0xE1F0, crc_err 0, frame_err 0.
- Frame data 0xFF, CRC 0xFF01 (1 bit corrupted from 0xFF00) -> rx_valid, crc_out 0xFF01, crc_err 1. With the macro undefined -> crc_err 0.
- Frame data 0x5A, stop bit 0, line held low 3 bit times, then high for 1 bit time and a good frame 0x00/0xE1F0 -> first frame strobes with frame_err 1; no further strobe while the line is low; second frame received clean.
- Low glitch of DIV/4 cycles on an idle line -> rx_busy returns low by cycle HALF+1; no rx_valid.
- reset_n pulsed low during the CRC field -> all outputs 0 immediately; the next full frame 0xFF/0xFF00 is received correctly.
- Two frames with zero idle gap (0x00/0xE1F0 then 0xFF/0xFF00) -> two rx_valid pulses exactly 26*DIV cycles apart, both error-free.

Source files
------------

// File: rtl/uart_crc_receiver.sv
// UART receiver for 26-bit frames: start, 8 data, 16 CRC (all LSB-first), stop.
// Define UART_RX_CRC_CHECK_EN to recompute CRC-16 over the data byte and drive crc_err.
module uart_crc_receiver #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter logic [15:0] CRC_POLY  = 16'h1021,
   parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_in,
   output logic [7:0]  data_out,
   output logic [15:0] crc_out,
   output logic        rx_valid,
   output logic        crc_err,
   output logic        frame_err,
   output logic        rx_busy
);

   localparam int unsigned DIV_I = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] DIV   = 16'(DIV_I);
   localparam logic [15:0] HALF  = 16'(DIV_I / 2);

   typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, rxs_q, rxs_prev_q;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  dsh_q, dsh_d;
   logic [15:0] csh_q, csh_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [15:0] crc_out_q, crc_out_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        bit_tick, stop_tick;

   assign bit_tick  = (cnt_q == DIV);
   assign stop_tick = (state_q == STOP) && bit_tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         dsh_q       <= '0;
         csh_q       <= '0;
         data_out_q  <= '0;
         crc_out_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= rx_in;
         rxs_q       <= sync1_q;
         rxs_prev_q  <= rxs_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         dsh_q       <= dsh_d;
         csh_q       <= csh_d;
         data_out_q  <= data_out_d;
         crc_out_q   <= crc_out_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Counter restarts at 1 so that a sample falls exactly DIV cycles after the previous one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      dsh_d   = dsh_q;
      csh_d   = csh_q;
      case (state_q)
         IDLE: begin
            cnt_d = 16'd1;
            bit_d = '0;
            if (rxs_prev_q && !rxs_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = 16'd1;
               state_d = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d = 16'd1;
               dsh_d = {rxs_q, dsh_q[7:1]};
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd7) begin
                  bit_d   = '0;
                  state_d = CRC;
               end
            end
         end
         CRC: begin
            if (bit_tick) begin
               cnt_d = 16'd1;
               csh_d = {rxs_q, csh_q[15:1]};
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd15) begin
                  bit_d   = '0;
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_valid_d  = stop_tick;
      data_out_d  = stop_tick ? dsh_q : data_out_q;
      crc_out_d   = stop_tick ? csh_q : crc_out_q;
      frame_err_d = stop_tick ? ~rxs_q : frame_err_q;
   end

`ifdef UART_RX_CRC_CHECK_EN
   logic crc_err_q, crc_err_d;

   // MSB-first, non-reflected CRC over one byte, no final XOR.
   function automatic logic [15:0] crc16_byte(input logic [7:0] d);
      logic [15:0] c;
      logic        fb;
      c = CRC_INIT;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ CRC_POLY;
      end
      return c;
   endfunction

   always_comb begin
      crc_err_d = stop_tick ? (crc16_byte(dsh_q) != csh_q) : crc_err_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) crc_err_q <= 1'b0;
      else          crc_err_q <= crc_err_d;
   end

   assign crc_err = crc_err_q;
`else
   logic unused_crc_cfg;
   assign unused_crc_cfg = ^{CRC_POLY, CRC_INIT};
   assign crc_err        = 1'b0;
`endif

   assign data_out  = data_out_q;
   assign crc_out   = crc_out_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_crc_receiver.sv
// Scoreboard bench for uart_crc_receiver: directed frames with expected results queued at send time.
module tb_uart_crc_receiver;

   localparam int unsigned CLK_FREQ  = 1000;
   localparam int unsigned BAUD_RATE = 100;
   localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF      = DIV / 2;

`ifdef UART_RX_CRC_CHECK_EN
   localparam logic CRC_EN = 1'b1;
`else
   localparam logic CRC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_in = 1'b1;
   logic [7:0]  data_out;
   logic [15:0] crc_out;
   logic        rx_valid, crc_err, frame_err, rx_busy;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          n_pushed = 0;
   int          n_seen = 0;

   typedef struct {
      logic [7:0]  d;
      logic [15:0] c;
      logic        ce;
      logic        fe;
      int unsigned at;
   } exp_t;
   exp_t exp_q[$];

   uart_crc_receiver #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE),
      .CRC_POLY (16'h1021),
      .CRC_INIT (16'hFFFF)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx_in    (rx_in),
      .data_out (data_out),
      .crc_out  (crc_out),
      .rx_valid (rx_valid),
      .crc_err  (crc_err),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         n_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_valid: got strobe at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data_out",  32'(data_out),  32'(e.d));
            chk("crc_out",   32'(crc_out),   32'(e.c));
            chk("crc_err",   32'(crc_err),   32'(e.ce));
            chk("frame_err", 32'(frame_err), 32'(e.fe));
            chk("valid_cycle", cyc, e.at);
         end
      end
   end

   task automatic drive_bits(input logic [25:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         rx_in = fr[i];
         repeat (DIV) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [15:0] c, input logic stop,
                             input logic exp_ce);
      exp_t e;
      e.d  = d;
      e.c  = c;
      e.ce = exp_ce;
      e.fe = ~stop;
      e.at = cyc + 3 + HALF + 25 * DIV;
      exp_q.push_back(e);
      n_pushed++;
      drive_bits({stop, c, d, 1'b0}, 26);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_neg(input int unsigned t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data_out"},  32'(data_out),  32'h0);
      chk({tag, "_crc_out"},   32'(crc_out),   32'h0);
      chk({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
      chk({tag, "_crc_err"},   32'(crc_err),   32'h0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
      chk({tag, "_rx_busy"},   32'(rx_busy),   32'h0);
   endtask

   initial begin
      int unsigned n0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      reset_n = 1'b1;
      idle(DIV);

      // Clean frame: CRC-16/CCITT-FALSE of 0x00 is 0xE1F0
      send_frame(8'h00, 16'hE1F0, 1'b1, 1'b0);
      idle(DIV);

      // 0xFF should carry 0xFF00; one bit flipped
      send_frame(8'hFF, 16'hFF01, 1'b1, CRC_EN);
      idle(DIV);

      // Correct CRC for 0x5A is 0x1A4F; stop bit low, line stays low, then a clean frame
      send_frame(8'h5A, 16'h1A4F, 1'b0, 1'b0);
      rx_in = 1'b0;
      repeat (3 * DIV) @(posedge clk);
      #1;
      idle(DIV);
      send_frame(8'h00, 16'hE1F0, 1'b1, 1'b0);
      idle(DIV);

      // Short low glitch: false start, back to idle right after the HALF check
      n0 = cyc;
      rx_in = 1'b0;
      repeat (DIV / 4) @(posedge clk);
      #1;
      rx_in = 1'b1;
      at_neg(n0 + 3);
      chk("glitch_busy_c1", 32'(rx_busy), 32'h1);
      at_neg(n0 + 2 + HALF);
      chk("glitch_busy_half", 32'(rx_busy), 32'h1);
      at_neg(n0 + 3 + HALF);
      chk("glitch_busy_half_p1", 32'(rx_busy), 32'h0);
      @(posedge clk);
      #1;
      idle(DIV);

      // Reset in the middle of the CRC field, then a full frame
      drive_bits({1'b1, 16'hFF00, 8'hFF, 1'b0}, 14);
      chk("pre_reset_busy", 32'(rx_busy), 32'h1);
      reset_n = 1'b0;
      rx_in   = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(2 * DIV);
      send_frame(8'hFF, 16'hFF00, 1'b1, 1'b0);

      // Back-to-back frames, no idle gap: strobes 26*DIV apart
      send_frame(8'h00, 16'hE1F0, 1'b1, 1'b0);
      send_frame(8'hFF, 16'hFF00, 1'b1, 1'b0);
      idle(3 * DIV);

      chk("pending_expectations", 32'(exp_q.size()), 32'h0);
      chk("strobe_count", 32'(n_seen), 32'(n_pushed));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
